// File: rtl/out_port_fnd_ctrl_if.sv
// Display-stage bus: value capture strobe in, busy flag and 7-segment drive out.
interface out_port_fnd_ctrl_if;
    logic [7:0] dataIn;
    logic       dataValid;
    logic       busy;
    logic [3:0] fndCom;
    logic [7:0] fndFont;

    modport master (
        output dataIn,
        output dataValid,
        input  busy,
        input  fndCom,
        input  fndFont
    );

    modport slave (
        input  dataIn,
        input  dataValid,
        output busy,
        output fndCom,
        output fndFont
    );
endinterface

// File: rtl/out_port_fnd_ctrl.sv
// out_port_fnd_ctrl: captures an 8-bit processor output value, converts it to
// BCD with a sequential double-dabble engine (8 iterations) and scans the
// result onto a 4-digit common-anode 7-segment display (active-low).
// Optional build macro FND_LEADING_ZERO_BLANK_EN blanks leading zero digits
// (digit 0 always shows a numeral).
module out_port_fnd_ctrl #(
    parameter int REFRESH_DIV = 100_000
) (
    input  logic                 clk,
    input  logic                 reset,
    out_port_fnd_ctrl_if.slave   bus
);

    localparam int CNT_W = $clog2(REFRESH_DIV);

    typedef enum logic [1:0] {IDLE, CONV, LOAD} state_t;

    state_t           state;
    logic [19:0]      shiftReg;
    logic [2:0]       iterCnt;
    logic             pendValid;
    logic [7:0]       pendData;
    logic [3:0]       digits [4];
    logic [3:0]       blank;
    logic [CNT_W-1:0] refreshCnt;
    logic [1:0]       digitIdx;
    logic [1:0]       idxNext;
    logic             scanWrap;

    // Active-low segment pattern (bit7 = dp, kept off) for one BCD code.
    function automatic logic [7:0] fontOf(input logic [3:0] d);
        case (d)
            4'd0:    fontOf = 8'hC0;
            4'd1:    fontOf = 8'hF9;
            4'd2:    fontOf = 8'hA4;
            4'd3:    fontOf = 8'hB0;
            4'd4:    fontOf = 8'h99;
            4'd5:    fontOf = 8'h92;
            4'd6:    fontOf = 8'h82;
            4'd7:    fontOf = 8'hF8;
            4'd8:    fontOf = 8'h80;
            4'd9:    fontOf = 8'h90;
            default: fontOf = 8'hFF;
        endcase
    endfunction

    // One double-dabble iteration: add-3 correction on each BCD nibble, then shift.
    function automatic logic [19:0] dabbleStep(input logic [19:0] s);
        logic [19:0] t;
        t = s;
        if (t[11:8]  >= 4'd5) t[11:8]  = t[11:8]  + 4'd3;
        if (t[15:12] >= 4'd5) t[15:12] = t[15:12] + 4'd3;
        if (t[19:16] >= 4'd5) t[19:16] = t[19:16] + 4'd3;
        dabbleStep = {t[18:0], 1'b0};
    endfunction

    // Conversion FSM with one-deep pending slot; display digits change only in LOAD.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            bus.busy  <= 1'b0;
            pendValid <= 1'b0;
            iterCnt   <= 3'd0;
            for (int i = 0; i < 4; i++) digits[i] <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.dataValid) begin
                        shiftReg <= {12'b0, bus.dataIn};
                        iterCnt  <= 3'd0;
                        state    <= CONV;
                        bus.busy <= 1'b1;
                    end
                end
                CONV: begin
                    shiftReg <= dabbleStep(shiftReg);
                    iterCnt  <= iterCnt + 3'd1;
                    if (iterCnt == 3'd7) state <= LOAD;
                    if (bus.dataValid) begin
                        pendData  <= bus.dataIn;
                        pendValid <= 1'b1;
                    end
                end
                LOAD: begin
                    digits[0] <= shiftReg[11:8];
                    digits[1] <= shiftReg[15:12];
                    digits[2] <= shiftReg[19:16];
                    digits[3] <= 4'd0;
                    iterCnt   <= 3'd0;
                    if (pendValid) begin
                        // Older pending value converts now; a strobe on this edge refills the slot.
                        shiftReg  <= {12'b0, pendData};
                        state     <= CONV;
                        pendValid <= bus.dataValid;
                        if (bus.dataValid) pendData <= bus.dataIn;
                    end else if (bus.dataValid) begin
                        shiftReg <= {12'b0, bus.dataIn};
                        state    <= CONV;
                    end else begin
                        state    <= IDLE;
                        bus.busy <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end

    // Leading-zero blank flags derived from the displayed digits.
    always_comb begin
        blank = 4'b0000;
`ifdef FND_LEADING_ZERO_BLANK_EN
        blank[3] = (digits[3] == 4'd0);
        blank[2] = blank[3] && (digits[2] == 4'd0);
        blank[1] = blank[2] && (digits[1] == 4'd0);
`endif
    end

    // Next digit slot, advancing whenever the refresh counter wraps.
    always_comb begin
        scanWrap = (refreshCnt == CNT_W'(REFRESH_DIV - 1));
        idxNext  = scanWrap ? digitIdx + 2'd1 : digitIdx;
    end

    // Free-running scan; common and segment outputs registered together.
    always_ff @(posedge clk) begin
        if (reset) begin
            refreshCnt  <= '0;
            digitIdx    <= 2'd0;
            bus.fndCom  <= 4'b1110;
            bus.fndFont <= 8'hC0;
        end else begin
            refreshCnt  <= scanWrap ? '0 : refreshCnt + 1'b1;
            digitIdx    <= idxNext;
            bus.fndCom  <= ~(4'b0001 << idxNext);
            bus.fndFont <= blank[idxNext] ? 8'hFF : fontOf(digits[idxNext]);
        end
    end

endmodule

// File: tb/tb_out_port_fnd_ctrl.sv
// Directed bench for out_port_fnd_ctrl with REFRESH_DIV = 4.
module tb_out_port_fnd_ctrl;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    logic [7:0] fontTab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    out_port_fnd_ctrl_if bus();

    out_port_fnd_ctrl #(.REFRESH_DIV(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Advance one clock and land on the following falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Expected segment byte for digit position idx of a decimal value.
    function automatic logic [7:0] expDigitFont(input int value, input int idx);
        int p;
        p = 1;
        for (int i = 0; i < idx; i++) p = p * 10;
`ifdef FND_LEADING_ZERO_BLANK_EN
        if (idx > 0 && value < p) return 8'hFF;
`endif
        return fontTab[(value / p) % 10];
    endfunction

    function automatic int comIdx(input logic [3:0] com);
        case (com)
            4'b1110: return 0;
            4'b1101: return 1;
            4'b1011: return 2;
            4'b0111: return 3;
            default: return -1;
        endcase
    endfunction

    // Wait (bounded) for digit idx to be selected and return its segments.
    task automatic readFont(input int idx, output logic [7:0] f, output bit ok);
        logic [3:0] want;
        want = ~(4'b0001 << idx);
        ok = 1'b0;
        f = 8'hxx;
        for (int n = 0; n < 20 && !ok; n++) begin
            tick();
            if (bus.fndCom === want) begin
                ok = 1'b1;
                f = bus.fndFont;
            end
        end
    endtask

    // Wait (bounded) for the scan to wrap from digit 3 back to digit 0.
    task automatic syncScan(output bit ok);
        logic [3:0] prev;
        ok = 1'b0;
        prev = bus.fndCom;
        for (int n = 0; n < 40 && !ok; n++) begin
            tick();
            if (prev === 4'b0111 && bus.fndCom === 4'b1110) ok = 1'b1;
            else prev = bus.fndCom;
        end
    endtask

    task automatic startConv(input logic [7:0] v);
        bus.dataIn = v;
        bus.dataValid = 1'b1;
        tick();
        bus.dataValid = 1'b0;
    endtask

    task automatic test_reset();
        bit ok;
        logic [3:0] expCom;
        reset = 1'b1;
        bus.dataValid = 1'b0;
        bus.dataIn = 8'd0;
        tick();
        tick();
        checks++;
        if (bus.busy !== 1'b0 || bus.fndCom !== 4'b1110 || bus.fndFont !== 8'hC0) begin
            errors++;
            $display("FAIL reset_state: busy=%b com=%b font=%h, required busy=0 com=1110 font=c0",
                     bus.busy, bus.fndCom, bus.fndFont);
        end
        reset = 1'b0;
        syncScan(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL reset_scan_sync: scan wrap not seen, required wrap within 40 clocks");
        end
        for (int k = 0; k < 16; k++) begin
            expCom = ~(4'b0001 << (k / 4));
            checks++;
            if (bus.fndCom !== expCom || bus.fndFont !== expDigitFont(0, k / 4)) begin
                errors++;
                $display("FAIL reset_scan[%0d]: com=%b font=%h, required com=%b font=%h",
                         k, bus.fndCom, bus.fndFont, expCom, expDigitFont(0, k / 4));
            end
            tick();
        end
    endtask

    task automatic test_scan_255();
        bit ok;
        int n;
        logic [3:0] expCom;
        startConv(8'd255);
        n = 0;
        while (bus.busy === 1'b1 && n < 30) begin
            n++;
            tick();
        end
        checks++;
        if (n != 9) begin
            errors++;
            $display("FAIL busy_length_255: busy high %0d cycles, required 9", n);
        end
        syncScan(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL scan255_sync: scan wrap not seen, required wrap within 40 clocks");
        end
        for (int k = 0; k < 20; k++) begin
            expCom = ~(4'b0001 << ((k / 4) % 4));
            checks++;
            if (bus.fndCom !== expCom || bus.fndFont !== expDigitFont(255, (k / 4) % 4)) begin
                errors++;
                $display("FAIL scan255[%0d]: com=%b font=%h, required com=%b font=%h",
                         k, bus.fndCom, bus.fndFont, expCom, expDigitFont(255, (k / 4) % 4));
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        int idx;
        int expVal;
        logic [7:0] f;
        bit ok;
        for (int k = 0; k < 20; k++) begin
            bus.dataValid = (k == 0 || k == 3 || k == 5);
            bus.dataIn = (k == 0) ? 8'd12 : (k == 3) ? 8'd200 : (k == 5) ? 8'd77 : 8'd0;
            tick();
            bus.dataValid = 1'b0;
            if (k <= 18) begin
                checks++;
                if (bus.busy !== (k <= 17)) begin
                    errors++;
                    $display("FAIL b2b_busy[E%0d]: busy=%b, required %b", k, bus.busy, k <= 17);
                end
            end
            if (k >= 1) begin
                expVal = (k <= 9) ? 255 : (k <= 18) ? 12 : 77;
                idx = comIdx(bus.fndCom);
                checks++;
                if (idx < 0 || bus.fndFont !== expDigitFont(expVal, idx)) begin
                    errors++;
                    $display("FAIL b2b_display[E%0d]: com=%b font=%h, required value %0d shown",
                             k, bus.fndCom, bus.fndFont, expVal);
                end
            end
        end
        for (int d = 0; d < 4; d++) begin
            readFont(d, f, ok);
            checks++;
            if (!ok || f !== expDigitFont(77, d)) begin
                errors++;
                $display("FAIL b2b_final_digit%0d: font=%h, required %h", d, f, expDigitFont(77, d));
            end
        end
    endtask

    task automatic test_reset_abort();
        int n;
        int idx;
        startConv(8'd128);
        n = 0;
        while (bus.busy === 1'b1 && n < 30) begin
            n++;
            tick();
        end
        checks++;
        if (n != 9) begin
            errors++;
            $display("FAIL abort_prior_conv: busy high %0d cycles, required 9", n);
        end
        startConv(8'd99);
        tick();
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (bus.busy !== 1'b0 || bus.fndCom !== 4'b1110 || bus.fndFont !== 8'hC0) begin
            errors++;
            $display("FAIL abort_reset_state: busy=%b com=%b font=%h, required busy=0 com=1110 font=c0",
                     bus.busy, bus.fndCom, bus.fndFont);
        end
        for (int k = 0; k < 24; k++) begin
            tick();
            idx = comIdx(bus.fndCom);
            checks++;
            if (bus.busy !== 1'b0 || idx < 0 || bus.fndFont !== expDigitFont(0, idx)) begin
                errors++;
                $display("FAIL abort_no_late_update[%0d]: busy=%b com=%b font=%h, required busy=0 and 0000",
                         k, bus.busy, bus.fndCom, bus.fndFont);
            end
        end
    endtask

    task automatic test_boundary();
        int vals [6] = '{0, 9, 10, 99, 100, 7};
        logic [7:0] f;
        bit ok;
        for (int v = 0; v < 6; v++) begin
            startConv(8'(vals[v]));
            for (int c = 0; c < 9; c++) tick();
            checks++;
            if (bus.busy !== 1'b0) begin
                errors++;
                $display("FAIL boundary_busy_%0d: busy=%b after 9 clocks, required 0", vals[v], bus.busy);
            end
            for (int d = 0; d < 4; d++) begin
                readFont(d, f, ok);
                checks++;
                if (!ok || f !== expDigitFont(vals[v], d)) begin
                    errors++;
                    $display("FAIL boundary_%0d_digit%0d: font=%h, required %h",
                             vals[v], d, f, expDigitFont(vals[v], d));
                end
            end
        end
    endtask

    initial begin
        bus.dataIn = 8'd0;
        bus.dataValid = 1'b0;
        @(negedge clk);
        test_reset();
        test_scan_255();
        test_back_to_back();
        test_reset_abort();
        test_boundary();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/out_port_fnd_ctrl.md
Name: out_port_fnd_ctrl

Overview:
Downstream display stage for the dedicated processor. It captures the 8-bit outPort value on a valid strobe and converts it to BCD with a sequential double-dabble engine. It time-multiplexes the result onto a 4-digit common-anode 7-segment display (active-low fndCom/fndFont). It sits at the top level beside top_DedicatedProcessor; the top drives dataValid from the processor's output-buffer enable.

Parameters:
REFRESH_DIV, 100_000, clocks per digit slot (1 kHz digit rate at 100 MHz); legal range ≥ 2; a small value such as 4 is used in simulation.

Ports:
clk        input   1  system clock, all logic on rising edge
reset      input   1  synchronous, active-high reset
dataIn     input   8  unsigned value to display (processor outPort)
dataValid  input   1  capture strobe, one clock per value
busy       output  1  high while a conversion is in progress
fndCom     output  4  digit enable, active-low one-hot; bit0 = ones digit
fndFont    output  8  segments, active-low; bit7 = dp (always 1/off), bits[6:0] = gfedcba

Behaviour:
- Clock and reset: one clock domain, clk. reset is synchronous and active-high, sampled on the rising edge of clk only.
- Reset values:
  - FSM = IDLE; busy = 0; pending slot empty.
  - All four displayed digit registers = 0.
  - Refresh counter = 0; digit index = 0.
  - fndCom = 4'b1110; fndFont = 8'hC0.
- Reset mid-conversion aborts the conversion and discards the pending value. The display returns to 0000.
- FSM states: IDLE, CONV, LOAD. busy = (state != IDLE), registered.
- IDLE:
  - dataValid = 1 at edge E0 loads the shift register {12'b0, dataIn}, sets the iteration count to 0, and moves to CONV.
- CONV: one double-dabble iteration per clock.
  - For each BCD nibble (hundreds, tens, ones): if nibble ≥ 5, add 3 (4-bit add, no carry out).
  - Then shift the whole 20-bit register left by 1.
  - After the 8th iteration (edge E8) move to LOAD.
- LOAD (edge E9):
  - Copy ones/tens/hundreds into the display digit registers; thousands digit = 0.
  - If the pending slot is full, load it into the shift register, clear the slot, and go to CONV. Otherwise go to IDLE.
- Latency: the display digits change at edge E9, 9 clocks after capture. busy is high for exactly 9 cycles per conversion.
- dataValid while busy:
  - The value goes into a one-deep pending slot. The latest value wins and overwrites any older pending value. It is never dropped silently beyond that overwrite.
  - dataValid on the LOAD edge with the slot empty starts the new conversion directly.
- Display digits are only updated in LOAD, so the display never shows partial conversions.
- Scan:
  - The refresh counter counts 0..REFRESH_DIV-1 and wraps.
  - On wrap, the digit index increments 0→1→2→3→0.
  - fndCom = ~(4'b0001 << index). fndFont = font(digit[index]).
  - Both outputs are registered and update together, so there is no glitch between them.
- Font (active-low): 0 C0, 1 F9, 2 A4, 3 B0, 4 99, 5 92, 6 82, 7 F8, 8 80, 9 90. Any other code gives FF.
- Scanning runs continuously and independently of conversions.

Optional Feature:
- Macro: FND_LEADING_ZERO_BLANK_EN.
- Defined: a digit is blanked (fndFont = 8'hFF) if it and all higher digits are 0, except digit 0, which always shows a numeral. Blank flags are computed from the display registers.
- Undefined: all four digits always show numerals; the thousands digit shows "0".

Test Plan:
- Reset held 2 cycles → fndCom=1110, fndFont=C0, busy=0. The scan then cycles through all digits showing C0.
- REFRESH_DIV=4, dataIn=255 with dataValid for 1 clk → busy high 9 cycles. Then digits 5,5,2,0 appear as font 92/1110, 92/1101, A4/1011, C0/0111, each held 4 clocks, in order 0,1,2,3,0.
- dataIn=12 at E0, 200 at E0+3, 77 at E0+5 → display shows 012 at E9. The conversion restarts at E9, busy stays high continuously, and the display shows 077 at E18. 200 is never displayed.
- Convert 128, then assert reset at E4 of a conversion of 99 → busy=0 and display 0000 the cycle after reset. No late update to 099 occurs.
- Boundary values 0, 9, 10, 99, 100 → digits 000, 009, 010, 099, 100, each exact after 9 cycles.
- With FND_LEADING_ZERO_BLANK_EN, value 7 → digits 1–3 = FF and digit 0 = F8; value 0 → digit 0 = C0 and the rest FF. Without the macro, value 7 → C0, C0, C0, F8.
